// File: rtl/cadence_gen.sv
// Pedal cadence sensor model: drives a square-wave cadence line whose half-period
// is programmable in prescaler ticks, optionally adding contact-bounce glitch
// pairs on every edge so the downstream debouncer gets exercised.
module cadence_gen #(
  parameter int FAST_SIM    = 0,
  parameter int BOUNCE_CLKS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [11:0] half_period,
  input  logic [2:0]  bounce_num,
  output logic        cadence,
  output logic        cadence_rise,
  output logic [7:0]  rev_cnt,
  output logic        busy
);

  localparam int TICK = (FAST_SIM != 0) ? 8 : 1024;
  localparam int TW   = $clog2(TICK);
  localparam int BW   = (BOUNCE_CLKS > 1) ? $clog2(BOUNCE_CLKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK - 1);
  localparam logic [BW-1:0] BNC_LAST  = BW'(BOUNCE_CLKS - 1);

  typedef enum logic [2:0] {IDLE, BNC_R, HIGH, BNC_F, LOW} state_e;

  state_e       state_q, state_d;
  logic         cad_q, cad_d;
  logic         rise_q, rise_d;
  logic [7:0]   rev_q, rev_d;
  logic [11:0]  hp_q, hp_d;       // latched half-period of the current phase
  logic [11:0]  ph_q, ph_d;       // tick index within the phase, 1..hp
  logic [TW-1:0] tick_q, tick_d;  // prescaler
  logic [2:0]   bn_q, bn_d;       // latched glitch-pair count
  logic [BW-1:0] bcnt_q, bcnt_d;  // clk count within a glitch segment
  logic [3:0]   seg_q, seg_d;     // glitch segment index, 0..2*bn-1

  logic [11:0]  hp_eff;
  logic [3:0]   seg_last;
  logic         enter_bnc_r, enter_high, enter_bnc_f, enter_low;

  assign hp_eff   = (half_period == 12'd0) ? 12'd1 : half_period;
  assign seg_last = {bn_q, 1'b0} - 4'd1;

  assign cadence      = cad_q;
  assign cadence_rise = rise_q;
  assign rev_cnt      = rev_q;
  assign busy         = (state_q != IDLE);

  // State and datapath registers; reset aborts any phase in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cad_q   <= 1'b0;
      rise_q  <= 1'b0;
      rev_q   <= '0;
      hp_q    <= 12'd1;
      ph_q    <= 12'd1;
      tick_q  <= '0;
      bn_q    <= '0;
      bcnt_q  <= '0;
      seg_q   <= '0;
    end else begin
      state_q <= state_d;
      cad_q   <= cad_d;
      rise_q  <= rise_d;
      rev_q   <= rev_d;
      hp_q    <= hp_d;
      ph_q    <= ph_d;
      tick_q  <= tick_d;
      bn_q    <= bn_d;
      bcnt_q  <= bcnt_d;
      seg_q   <= seg_d;
    end
  end

  // Next-state: decide which state to enter, then apply that state's entry actions.
  always_comb begin
    state_d     = state_q;
    cad_d       = cad_q;
    rise_d      = 1'b0;
    rev_d       = rev_q;
    hp_d        = hp_q;
    ph_d        = ph_q;
    tick_d      = tick_q;
    bn_d        = bn_q;
    bcnt_d      = bcnt_q;
    seg_d       = seg_q;
    enter_bnc_r = 1'b0;
    enter_high  = 1'b0;
    enter_bnc_f = 1'b0;
    enter_low   = 1'b0;

    case (state_q)
      IDLE: begin
        if (en) begin
          if (bounce_num != 3'd0) enter_bnc_r = 1'b1;
          else                    enter_high  = 1'b1;
        end
      end
      BNC_R, BNC_F: begin
        // Glitch segments run on raw clk, not prescaled ticks.
        if (bcnt_q == BNC_LAST) begin
          bcnt_d = '0;
          if (seg_q == seg_last) begin
            if (state_q == BNC_R) enter_high = 1'b1;
            else                  enter_low  = 1'b1;
          end else begin
            seg_d = seg_q + 4'd1;
            cad_d = ~cad_q;
          end
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      HIGH, LOW: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (ph_q == hp_q) begin
            // Last clk of tick hp: phase expires here.
            if (state_q == HIGH) begin
              if (bounce_num != 3'd0) enter_bnc_f = 1'b1;
              else                    enter_low   = 1'b1;
            end else if (en) begin
              if (bounce_num != 3'd0) enter_bnc_r = 1'b1;
              else                    enter_high  = 1'b1;
            end else begin
              state_d = IDLE;
              cad_d   = 1'b0;
            end
          end else begin
            ph_d = ph_q + 12'd1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cad_d   = 1'b0;
      end
    endcase

    if (enter_bnc_r || enter_bnc_f) begin
      state_d = enter_bnc_r ? BNC_R : BNC_F;
      cad_d   = enter_bnc_r;
      bn_d    = bounce_num;
      bcnt_d  = '0;
      seg_d   = '0;
    end
    if (enter_high || enter_low) begin
      // Prescaler restarts on every phase entry so phase length is exact.
      state_d = enter_high ? HIGH : LOW;
      cad_d   = enter_high;
      rise_d  = enter_high;
      hp_d    = hp_eff;
      ph_d    = 12'd1;
      tick_d  = '0;
      if (enter_high) rev_d = rev_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_cadence_gen.sv
// Bench for cadence_gen (FAST_SIM=1, BOUNCE_CLKS=4): table of phase/period
// vectors plus directed sequences for bounce shape, stop, re-latching, reset
// and rev_cnt wrap.
module tb_cadence_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [11:0] half_period = 12'd4;
  logic [2:0]  bounce_num = 3'd0;
  logic        cadence, cadence_rise, busy;
  logic [7:0]  rev_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cadence_gen #(.FAST_SIM(1), .BOUNCE_CLKS(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .half_period(half_period),
    .bounce_num(bounce_num), .cadence(cadence), .cadence_rise(cadence_rise),
    .rev_cnt(rev_cnt), .busy(busy)
  );

  typedef struct {
    logic [11:0] hp;
    logic [2:0]  bn;
    int          exp_hi;   // solid HIGH length in clk
    int          exp_per;  // rise-to-rise period in clk
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Advance on negedges until cadence_rise is seen; timeout counts as a failure.
  task automatic wait_rise(input string name, input int limit);
    int n = 0;
    while (!cadence_rise && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!cadence_rise) check(name, 0, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt, hi, lo;
    logic low_seen;
    logic [15:0] pat;

    vecs[0] = '{hp: 12'd4, bn: 3'd0, exp_hi: 32, exp_per: 64};
    vecs[1] = '{hp: 12'd0, bn: 3'd0, exp_hi: 8,  exp_per: 16};
    vecs[2] = '{hp: 12'd4, bn: 3'd2, exp_hi: 32, exp_per: 96};
    vecs[3] = '{hp: 12'd1, bn: 3'd1, exp_hi: 8,  exp_per: 32};
    vecs[4] = '{hp: 12'd3, bn: 3'd3, exp_hi: 24, exp_per: 96};
    vecs[5] = '{hp: 12'd2, bn: 3'd7, exp_hi: 16, exp_per: 144};

    // Reset state
    do_reset();
    check("reset_cadence", cadence, 0);
    check("reset_rise", cadence_rise, 0);
    check("reset_rev", rev_cnt, 0);
    check("reset_busy", busy, 0);

    // Table: solid-high length, period, revolution count
    foreach (vecs[i]) begin
      do_reset();
      half_period = vecs[i].hp;
      bounce_num  = vecs[i].bn;
      en = 1'b1;
      wait_rise($sformatf("v%0d_first_rise", i), 500);
      cnt = 0; hi = 0; low_seen = 1'b0;
      do begin
        if (cadence && !low_seen) hi++;
        else low_seen = 1'b1;
        @(negedge clk);
        cnt++;
      end while (!cadence_rise && cnt < 2000);
      check($sformatf("v%0d_high_len", i), hi, vecs[i].exp_hi);
      check($sformatf("v%0d_period", i), cnt, vecs[i].exp_per);
      check($sformatf("v%0d_rev", i), rev_cnt, 2);
      check($sformatf("v%0d_busy", i), busy, 1);
      en = 1'b0;
    end

    // Bounce shape on the rising edge: 1111 0000 1111 0000 then solid high
    do_reset();
    half_period = 12'd4; bounce_num = 3'd2; en = 1'b1;
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      pat[15-k] = cadence;
      if (cadence_rise) cnt++;
    end
    check("bnc_pattern", pat, 16'hF0F0);
    check("bnc_no_rise", cnt, 0);
    @(negedge clk);
    check("bnc_solid_cad", cadence, 1);
    check("bnc_solid_rise", cadence_rise, 1);

    // en dropped mid-HIGH: HIGH and LOW complete, then IDLE
    do_reset();
    half_period = 12'd4; bounce_num = 3'd0; en = 1'b1;
    wait_rise("stop_rise", 100);
    cnt = 0;
    repeat (10) begin @(negedge clk); cnt++; end
    en = 1'b0;
    while (busy && cnt < 500) begin @(negedge clk); cnt++; end
    check("stop_len", cnt, 64);
    check("stop_cad", cadence, 0);
    check("stop_rev", rev_cnt, 1);
    repeat (100) @(negedge clk);
    check("stop_rev_hold", rev_cnt, 1);
    check("stop_busy_hold", busy, 0);

    // half_period 4->8 mid-HIGH: this HIGH 32, next LOW 64
    do_reset();
    half_period = 12'd4; bounce_num = 3'd0; en = 1'b1;
    wait_rise("hp_rise", 100);
    hi = 0; lo = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      hi++;
    end
    half_period = 12'd8;
    while (cadence && hi < 500) begin @(negedge clk); hi++; end
    while (!cadence && lo < 500) begin @(negedge clk); lo++; end
    check("hp_cur_high", hi, 32);
    check("hp_next_low", lo, 64);

    // Reset asserted mid-BNC_R of the second revolution
    do_reset();
    half_period = 12'd4; bounce_num = 3'd2; en = 1'b1;
    wait_rise("rst_rise", 100);
    repeat (83) @(negedge clk);
    check("rst_pre_cad", cadence, 1);
    check("rst_pre_rev", rev_cnt, 1);
    check("rst_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_cad", cadence, 0);
    check("rst_rise", cadence_rise, 0);
    check("rst_rev", rev_cnt, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    bounce_num = 3'd0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_restart_cad", cadence, 1);

    // 256 revolutions: rev_cnt wraps 255 -> 0
    do_reset();
    half_period = 12'd0; bounce_num = 3'd0; en = 1'b1;
    cnt = 0;
    while (rev_cnt != 8'd255 && cnt < 5000) begin @(negedge clk); cnt++; end
    check("wrap_reach_255", rev_cnt, 255);
    @(negedge clk);
    wait_rise("wrap_rise", 40);
    check("wrap_zero", rev_cnt, 0);
    en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
